alu_req_driver: RTL and testbench
=================================

Name: alu_req_driver

Overview:
Upstream issue stage for the 8-bit 4-op ALU (op 0:add, 1:sub, 2:xor, 3:and; registered result, ack one cycle after req).
- Buffers tagged commands in a small FIFO and issues them one at a time as a single-cycle req pulse.
- Holds operands stable until ack, captures the result, and returns it with its tag on a valid/ready response port.
- Provides a timeout so a missing ack cannot hang the pipeline.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of 2, 2..16
TIMEOUT, 15, maximum WAIT cycles without ack before an error response; 2..255

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept a command
cmd_op  in  2  opcode
cmd_a  in  8  operand a
cmd_b  in  8  operand b
cmd_tag  in  4  caller tag, returned with the result
alu_req  out  1  request pulse to ALU
alu_op  out  2  opcode to ALU
alu_a  out  8  operand a to ALU
alu_b  out  8  operand b to ALU
alu_ack  in  1  ALU acknowledge
alu_y  in  8  ALU result
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_y  out  8  result; 0 on error
rsp_tag  out  4  tag of the command
rsp_err  out  1  1 = timed out, no ack
busy  out  1  state != IDLE or FIFO non-empty
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is asynchronous; all state clears.
  - alu_req=0; alu_op/alu_a/alu_b=0; rsp_valid=0, rsp_y=0, rsp_tag=0, rsp_err=0; busy=0; fifo_count=0; cmd_ready=1.
  - Reset mid-operation discards the FIFO and any in-flight command; no response is produced.
- FIFO:
  - Push on cmd_valid && cmd_ready; cmd_ready = (fifo_count < DEPTH), independent of a same-cycle pop.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - Order is preserved (FIFO).
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO non-empty, pop the head at the edge, latch op/a/b/tag into the alu_* and tag registers, go to ISSUE. Otherwise stay.
  - ISSUE: alu_req=1 for exactly this one cycle; go to WAIT. Clear the timeout counter.
  - WAIT: alu_req=0; alu_op/a/b held at the latched values.
    - On alu_ack=1: capture alu_y into rsp_y, set rsp_err=0, go to RESP.
    - Otherwise increment the counter. If no ack arrives within TIMEOUT WAIT cycles, set rsp_y=0 and rsp_err=1, and go to RESP.
  - RESP: rsp_valid=1; rsp_y/tag/err held stable while rsp_ready=0.
    - On rsp_valid && rsp_ready: if the FIFO is non-empty, pop and go directly to ISSUE (rsp_valid low next cycle); else go to IDLE.
- alu_op/a/b change only on a pop; they keep their last value in IDLE.
- alu_ack outside WAIT is ignored.
- Nominal latency with the real ALU:
  - Command accepted at edge E0 → alu_req high in cycle after E1 → ack seen in WAIT after E2 → rsp_valid high after E3 (3 cycles).
  - Back-to-back throughput is one result per 3 cycles with rsp_ready held high.
- Responses are produced in command order.
- No arithmetic is performed here; widths are passed through unchanged.

Test Plan:
1. Single command op=0, a=200, b=100, tag=5; ALU model with 1-cycle ack → rsp_valid exactly 3 cycles after acceptance, rsp_y=44 (wrap), rsp_tag=5, rsp_err=0; alu_req high for exactly 1 cycle.
2. op=1, a=5, b=10, then op=2, a=0xF0, b=0xFF, then op=3, a=0xAA, b=0x0F → responses 251, 0x0F, 0x0A in order with matching tags; alu_a/b stable from ISSUE through ack.
3. Burst of 6 commands with rsp_ready=0, DEPTH=4 → first command popped and held in RESP, 4 queued, cmd_ready=0 and fifo_count=4 while the 6th is stalled; after rsp_ready=1, all 6 responses arrive in order.
4. rsp_ready held 0 for 5 cycles in RESP → rsp_valid/y/tag/err constant; alu_req stays 0; no FIFO pop until the handshake.
5. alu_ack tied 0, TIMEOUT=15 → exactly 15 WAIT cycles, then rsp_valid=1, rsp_err=1, rsp_y=0; next command is issued normally after the handshake.
6. rst_n asserted during WAIT with 2 commands queued → outputs immediately take reset values, fifo_count=0, no response emitted; a new command after reset completes normally.

Source files
------------

// File: rtl/alu_req_driver.sv
// Issue stage for the 8-bit 4-op ALU: queues tagged commands, issues one req pulse per command,
// waits for ack (with timeout) and returns the result with its tag on a valid/ready port.
module alu_req_driver #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    input  logic [3:0]               cmd_tag,
    output logic                     alu_req,
    output logic [1:0]               alu_op,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    input  logic                     alu_ack,
    input  logic [7:0]               alu_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_y,
    output logic [3:0]               rsp_tag,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 22;
    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_d;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_d;
    logic [TW-1:0]   tmo, tmo_d;
    logic            push, pop;
    logic            alu_req_d, rsp_valid_d, rsp_err_d, cmd_ready_d, busy_d;
    logic [7:0]      rsp_y_d;

    assign push = cmd_valid && cmd_ready;
    assign head = mem[rd_ptr];

    // Command storage; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
    end

    // Next-state and next-value logic for every registered output
    always_comb begin
        state_d   = state;
        pop       = 1'b0;
        tmo_d     = tmo;
        rsp_y_d   = rsp_y;
        rsp_err_d = rsp_err;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_ack) begin
                    rsp_y_d   = alu_y;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else if (tmo == TW'(TIMEOUT - 1)) begin
                    rsp_y_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    tmo_d = tmo + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (fifo_count != '0) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        count_d     = fifo_count + CW'(push) - CW'(pop);
        alu_req_d   = (state_d == ISSUE);
        rsp_valid_d = (state_d == RESP);
        cmd_ready_d = (count_d < CW'(DEPTH));
        busy_d      = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tmo        <= '0;
            alu_req    <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_y      <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            fifo_count <= count_d;
            tmo        <= tmo_d;
            alu_req    <= alu_req_d;
            rsp_valid  <= rsp_valid_d;
            rsp_y      <= rsp_y_d;
            rsp_err    <= rsp_err_d;
            cmd_ready  <= cmd_ready_d;
            busy       <= busy_d;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            // Operands and tag are latched only on a pop and held until the next one
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                alu_op  <= head[21:20];
                alu_a   <= head[19:12];
                alu_b   <= head[11:4];
                rsp_tag <= head[3:0];
            end
        end
    end

endmodule

// File: tb/tb_alu_req_driver.sv
// Bench for alu_req_driver: directed latency/backpressure/timeout/reset steps plus a random phase,
// with responses checked against an in-order queue of expected ALU results.
module tb_alu_req_driver;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 15;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;
    logic [3:0] cmd_tag;
    logic       alu_req, alu_ack;
    logic [1:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_y;
    logic       rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0] rsp_y;
    logic [3:0] rsp_tag;
    logic [2:0] fifo_count;

    alu_req_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ack(alu_ack), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] y;
        logic [3:0] tag;
        logic       err;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic       accepted, prev_req, tmo_mode;
    logic       ack_en;
    int         ack_dly;
    logic [1:0] cap_op;
    logic [7:0] cap_a, cap_b, y_hold;
    int         pend;
    logic [7:0] s_y;
    logic [3:0] s_tag;
    logic       s_err;

    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return 8'(a + b);
            2'd1:    return 8'(a - b);
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // External ALU: registered result, ack ack_dly cycles after req (1 = nominal)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ack <= 1'b0;
            alu_y   <= '0;
            pend    <= 0;
            y_hold  <= '0;
        end else begin
            alu_ack <= 1'b0;
            alu_y   <= 8'($urandom);
            if (alu_req) begin
                y_hold <= alu_f(alu_op, alu_a, alu_b);
                if (ack_dly <= 1) begin
                    pend <= 0;
                    if (ack_en) begin
                        alu_ack <= 1'b1;
                        alu_y   <= alu_f(alu_op, alu_a, alu_b);
                    end
                end else begin
                    pend <= ack_dly - 1;
                end
            end else if (pend > 1) begin
                pend <= pend - 1;
            end else if (pend == 1) begin
                pend <= 0;
                if (ack_en) begin
                    alu_ack <= 1'b1;
                    alu_y   <= y_hold;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe the handshakes that will complete at the coming edge, then advance one cycle
    task automatic tick();
        exp_t e;
        if (cmd_valid && cmd_ready) begin
            e.y   = tmo_mode ? 8'd0 : alu_f(cmd_op, cmd_a, cmd_b);
            e.tag = cmd_tag;
            e.err = tmo_mode;
            q.push_back(e);
            accepted = 1'b1;
        end
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("rsp_y", 32'(rsp_y), 32'(e.y));
                chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
        if (alu_req) begin
            chk("req_single_cycle", 32'(prev_req), 32'd0);
            cap_op = alu_op;
            cap_a  = alu_a;
            cap_b  = alu_b;
        end
        if (alu_ack) begin
            chk("op_held", 32'(alu_op), 32'(cap_op));
            chk("a_held", 32'(alu_a), 32'(cap_a));
            chk("b_held", 32'(alu_b), 32'(cap_b));
        end
        prev_req = alu_req;
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
        int n;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = t;
        cmd_valid = 1'b1;
        accepted  = 1'b0;
        n = 0;
        while (!accepted && n < 40) begin
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("push_accepted", 32'(accepted), 32'd1);
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_in_time", 32'(n < bound), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
        rsp_ready = 1'b0; ack_en = 1'b1; ack_dly = 1; tmo_mode = 1'b0;
        accepted = 1'b0; prev_req = 1'b0; cap_op = '0; cap_a = '0; cap_b = '0;
        #12;
        chk("rst_req", 32'(alu_req), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ops", {8'd0, 6'(alu_op), alu_a, alu_b}, 32'd0);
        chk("rst_rsp", {19'd0, rsp_y, rsp_tag, rsp_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Single command: nominal 3-cycle latency and wrap-around add
        rsp_ready = 1'b1;
        push_one(2'd0, 8'd200, 8'd100, 4'd5);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_count", 32'(fifo_count), 32'd1);
        tick();
        chk("t1_req_e1", 32'(alu_req), 32'd1);
        chk("t1_a", 32'(alu_a), 32'd200);
        chk("t1_b", 32'(alu_b), 32'd100);
        chk("t1_op", 32'(alu_op), 32'd0);
        chk("t1_nrsp_e1", 32'(rsp_valid), 32'd0);
        tick();
        chk("t1_req_e2", 32'(alu_req), 32'd0);
        chk("t1_nrsp_e2", 32'(rsp_valid), 32'd0);
        tick();
        chk("t1_rsp_e3", 32'(rsp_valid), 32'd1);
        chk("t1_y", 32'(rsp_y), 32'd44);
        chk("t1_tag", 32'(rsp_tag), 32'd5);
        chk("t1_err", 32'(rsp_err), 32'd0);
        tick();
        chk("t1_rsp_done", 32'(rsp_valid), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Three ops in order: sub, xor, and
        push_one(2'd1, 8'd5, 8'd10, 4'd1);
        push_one(2'd2, 8'hF0, 8'hFF, 4'd2);
        push_one(2'd3, 8'hAA, 8'h0F, 4'd3);
        wait_drain(60);

        // Burst of 6 with consumer stalled: FIFO fills, response held stable
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_one(2'(i), 8'(17 * i + 3), 8'(29 * i + 1), 4'(8 + i));
        cmd_op = 2'd1; cmd_a = 8'd7; cmd_b = 8'd9; cmd_tag = 4'd13;
        cmd_valid = 1'b1;
        accepted  = 1'b0;
        s_y = rsp_y; s_tag = rsp_tag; s_err = rsp_err;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("t3_count", 32'(fifo_count), 32'd4);
            chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t4_rsp_hold", {19'd0, rsp_y, rsp_tag, rsp_err}, {19'd0, s_y, s_tag, s_err});
            chk("t4_no_req", 32'(alu_req), 32'd0);
        end
        chk("t3_stalled", 32'(accepted), 32'd0);
        rsp_ready = 1'b1;
        n = 0;
        while (!accepted && n < 40) begin
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("t3_sixth_accepted", 32'(accepted), 32'd1);
        wait_drain(100);

        // Missing ack: exactly TIMEOUT wait cycles, then an error response
        tmo_mode = 1'b1; ack_en = 1'b0; rsp_ready = 1'b0;
        push_one(2'd0, 8'd1, 8'd2, 4'd9);
        n = 0;
        while (!rsp_valid && n < 60) begin
            tick();
            n++;
        end
        chk("t5_latency", 32'(n), 32'(TIMEOUT + 2));
        chk("t5_err", 32'(rsp_err), 32'd1);
        chk("t5_y", 32'(rsp_y), 32'd0);
        chk("t5_tag", 32'(rsp_tag), 32'd9);
        rsp_ready = 1'b1;
        tick();
        tmo_mode = 1'b0; ack_en = 1'b1;
        push_one(2'd2, 8'h3C, 8'hC3, 4'd10);
        wait_drain(40);

        // Reset during WAIT with two commands queued
        ack_en = 1'b0;
        push_one(2'd0, 8'd10, 8'd20, 4'd1);
        push_one(2'd1, 8'd30, 8'd40, 4'd2);
        push_one(2'd3, 8'd50, 8'd60, 4'd3);
        tick();
        chk("t6_count_pre", 32'(fifo_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req", 32'(alu_req), 32'd0);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_count", 32'(fifo_count), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t6_ops", {8'd0, 6'(alu_op), alu_a, alu_b}, 32'd0);
        chk("t6_rsp", {19'd0, rsp_y, rsp_tag, rsp_err}, 32'd0);
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        ack_en = 1'b1;
        tick();
        chk("t6_quiet", 32'(rsp_valid), 32'd0);
        push_one(2'd1, 8'd100, 8'd1, 4'd6);
        wait_drain(40);

        // Random traffic with random ack latency and consumer backpressure
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom);
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_tag   = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            ack_dly   = int'($urandom_range(1, 3));
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain(200);
        chk("final_idle", 32'(busy), 32'd0);
        chk("final_empty", 32'(fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
